// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the multicycle RV32I core. A
//               word-organised unified memory behind a valid/ready
//               request/response handshake with a programmable number of
//               wait states, byte-enable writes and out-of-range errors.
//               Only one request is outstanding at a time.
//
// Parameters  : DEPTH_WORDS - number of 32-bit words (bytes 0..4*DEPTH-1)
//               WAIT_CYCLES - extra cycles between accept and response (0..15)
//
// Ports       : clk        in   system clock, rising edge
//               rst        in   asynchronous reset, active low
//               req_valid  in   request present
//               req_ready  out  responder can accept a request
//               req_we     in   1 = write, 0 = read
//               req_addr   in   byte address, word index = req_addr[31:2]
//               req_wdata  in   write data
//               req_be     in   byte enables, bit n covers wdata[8n+7:8n]
//               rsp_valid  out  response present
//               rsp_ready  in   initiator accepts response
//               rsp_rdata  out  read data, 0 for writes and errors
//               rsp_err    out  request out of range (or misaligned)
//
// Options     : `define MEMRSP_MISALIGN_ERR_EN to flag misaligned word and
//               halfword accesses as errors. When undefined the low address
//               bits are ignored and req_be is applied as given.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int          c_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [30:0] c_DEPTH = 31'(DEPTH_WORDS);
  localparam logic [3:0]  c_WAIT  = 4'(WAIT_CYCLES);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT_ST = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [1:0]      w_next_state;
  logic            w_accept;
  logic            w_rsp_done;
  logic            w_enter_resp;
  logic            w_acc_we;
  logic [31:0]     w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [3:0]      w_acc_be;
  logic            w_in_range;
  logic            w_misalign;
  logic            w_err;
  logic            w_commit_write;
  logic [c_AW-1:0] w_idx;

  // r_req_ready is only ever high in IDLE, so it alone qualifies acceptance.
  assign w_accept   = req_valid & r_req_ready;
  assign w_rsp_done = (r_state == c_RESP) & rsp_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_next_state = (c_WAIT == 4'd0) ? c_RESP : c_WAIT_ST;
        end
      end
      c_WAIT_ST: begin
        if (r_cnt <= 4'd1) begin
          w_next_state = c_RESP;
        end
      end
      c_RESP: begin
        if (rsp_ready) begin
          w_next_state = c_IDLE;
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  assign w_enter_resp = (r_state != c_RESP) && (w_next_state == c_RESP);

  // The access is performed on the edge that enters RESP. With zero wait
  // states that is the accepting edge itself, so the request must come
  // straight from the ports; otherwise it comes from the latched copy.
  assign w_acc_we    = (r_state == c_IDLE) ? req_we    : r_we;
  assign w_acc_addr  = (r_state == c_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == c_IDLE) ? req_wdata : r_wdata;
  assign w_acc_be    = (r_state == c_IDLE) ? req_be    : r_be;

  // Unsigned compare on the full 30-bit word index so wrap-around addresses
  // such as 0xFFFFFFFC are rejected rather than aliased.
  assign w_in_range = ({1'b0, w_acc_addr[31:2]} < c_DEPTH);
  assign w_idx      = w_acc_addr[c_AW+1:2];

`ifdef MEMRSP_MISALIGN_ERR_EN
  // Full-word access off a word boundary, or halfword access off a halfword
  // boundary, is rejected.
  assign w_misalign = ((w_acc_addr[1:0] != 2'b00) && (w_acc_be == 4'b1111)) ||
                      (((w_acc_be == 4'b0011) || (w_acc_be == 4'b1100)) &&
                       w_acc_addr[0]);
`else
  // Low address bits are deliberately ignored in this build.
  assign w_misalign = 1'b0 & (|w_acc_addr[1:0]);
`endif

  assign w_err          = !w_in_range || w_misalign;
  assign w_commit_write = rst && w_enter_resp && w_acc_we && !w_err;

  // --------------------------------------------------------------------------
  // Control and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      // Registered so that ready stays low throughout reset and rises on the
      // first edge after release.
      r_req_ready <= (w_next_state == c_IDLE);

      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= c_WAIT;
      end else if (r_state == c_WAIT_ST) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (!w_err && !w_acc_we) ? r_mem[w_idx] : 32'd0;
      end else if (w_rsp_done) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: never cleared by reset, byte-granular writes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = r_req_ready;
  assign rsp_valid = (r_state == c_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire
